// File: rtl/mc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for the RV32 core.
// Optional feature: define ILLEGAL_TRAP_EN to trap illegal opcodes (adds the trap port).
module mc_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          MEM_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [6:0]  op,
  input  logic        Reg_load,
  input  logic        mem_load,
  input  logic        do_store,
  input  logic        jump,
  input  logic        ALUbnc,
  input  logic        br_taken,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_sel,
  output logic [31:0] pc_init,
  output logic        rf_we,
  output logic        retire,
  output logic        mem_err,
`ifdef ILLEGAL_TRAP_EN
  output logic        trap,
`endif
  output logic [2:0]  state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;
`ifdef ILLEGAL_TRAP_EN
  localparam logic [2:0] S_TRAP   = 3'd7;
`endif

  logic [2:0] state_nxt;
  logic       legal;
  logic       commit;
  logic       timeout;
  logic       sel_q;
  logic       store_q;
  logic       rfw_q;
  logic       mem_err_q;

  always_comb begin
    legal = 1'b0;
    case (op)
      7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011,
      7'b1101111, 7'b1100111, 7'b1100011: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  // Timeout counter runs only while a request is outstanding without ready.
  generate
    if (MEM_TIMEOUT > 0) begin : g_timeout
      localparam int CW = $clog2(MEM_TIMEOUT + 1);
      logic [CW-1:0] cnt;
      logic          waiting;

      assign waiting = (imem_req & ~imem_ready) | (dmem_req & ~dmem_ready);
      assign timeout = waiting & (cnt == CW'(MEM_TIMEOUT - 1));

      always_ff @(posedge clk or posedge rst) begin
        if (rst)                          cnt <= '0;
        else if (!waiting)                cnt <= '0;
        else if (cnt != CW'(MEM_TIMEOUT)) cnt <= cnt + CW'(1);
      end
    end else begin : g_no_timeout
      assign timeout = 1'b0;
    end
  endgenerate

  assign imem_req = (state == S_FETCH);
  assign ir_we    = imem_req & imem_ready;
  assign dmem_req = (state == S_MEM);
  assign dmem_we  = dmem_req & store_q;
  assign commit   = (state == S_WB) | (dmem_req & dmem_ready & store_q);
  assign pc_we    = commit;
  assign retire   = commit;
  assign rf_we    = commit & rfw_q;
  assign pc_sel   = sel_q;
  assign pc_init  = RESET_PC;
  assign mem_err  = mem_err_q;
`ifdef ILLEGAL_TRAP_EN
  assign trap     = (state == S_TRAP);
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (run) state_nxt = S_FETCH;
      S_FETCH: begin
        if (imem_ready)   state_nxt = S_DECODE;
        else if (timeout) state_nxt = S_HALT;
      end
`ifdef ILLEGAL_TRAP_EN
      S_DECODE: state_nxt = legal ? S_EXEC : S_TRAP;
      S_TRAP:   state_nxt = S_TRAP;
`else
      S_DECODE: state_nxt = S_EXEC;
`endif
      S_EXEC:   state_nxt = (legal & (mem_load | do_store)) ? S_MEM : S_WB;
      S_MEM: begin
        if (dmem_ready) begin
          if (store_q) state_nxt = run ? S_FETCH : S_HALT;
          else         state_nxt = S_WB;
        end else if (timeout) begin
          state_nxt = S_HALT;
        end
      end
      S_WB:     state_nxt = run ? S_FETCH : S_HALT;
      S_HALT:   if (run) state_nxt = S_FETCH;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Decoder flags are captured in EXEC so MEM/commit see stable values;
  // an illegal op (non-trap build) is forced to behave as a NOP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      sel_q     <= 1'b0;
      store_q   <= 1'b0;
      rfw_q     <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_EXEC) begin
        sel_q   <= legal & (jump | (ALUbnc & br_taken));
        store_q <= legal & do_store;
        rfw_q   <= legal & Reg_load;
      end
      if (timeout) mem_err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mc_sequencer.sv
// Scoreboard bench for mc_sequencer: expected commit results are queued when an
// instruction is issued and checked when the DUT retires it.
module tb_mc_sequencer;

  logic        clk = 1'b0;
  logic        rst, run;
  logic [6:0]  op;
  logic        Reg_load, mem_load, do_store, jump, ALUbnc, br_taken;
  logic        imem_ready, dmem_ready;
  logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, rf_we, retire, mem_err;
  logic [31:0] pc_init;
  logic [2:0]  state;
`ifdef ILLEGAL_TRAP_EN
  logic        trap;
`endif

  mc_sequencer #(.RESET_PC(32'h0000_1000), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .run(run), .op(op),
    .Reg_load(Reg_load), .mem_load(mem_load), .do_store(do_store),
    .jump(jump), .ALUbnc(ALUbnc), .br_taken(br_taken),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .pc_init(pc_init),
    .rf_we(rf_we), .retire(retire), .mem_err(mem_err),
`ifdef ILLEGAL_TRAP_EN
    .trap(trap),
`endif
    .state(state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {logic rf; logic sel;} exp_t;
  exp_t sb[$];
  int   imem_lat = 0;
  int   dmem_lat = 0;
  int   retire_cnt = 0;

  function automatic logic legal_op(input logic [6:0] o);
    return o inside {7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011,
                     7'b1101111, 7'b1100111, 7'b1100011};
  endfunction

  // Memory responder: ready after <lat> waiting cycles of an outstanding request.
  initial begin
    int iw = 0;
    int dw = 0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (imem_req) begin imem_ready = (iw >= imem_lat); iw++; end
      else begin iw = 0; imem_ready = 1'b0; end
      if (dmem_req) begin dmem_ready = (dw >= dmem_lat); dw++; end
      else begin dw = 0; dmem_ready = 1'b0; end
    end
  end

  // Retirement monitor: pops the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && retire === 1'b1) begin
      retire_cnt++;
      chk("sb_depth", 32'(sb.size()) > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_rf_we", rf_we, e.rf);
        chk("sb_pc_sel", pc_sel, e.sel);
        chk("sb_pc_we", pc_we, 1);
      end
    end
  end

  // Called at a negedge in FETCH; returns at the negedge after commit.
  task automatic run_instr(input string name, input logic [6:0] o,
                           input logic rl, input logic ml, input logic st,
                           input logic jp, input logic bnc, input logic bt,
                           input int exp_lat, input int exp_dreq, input logic exp_wb);
    int   cyc;
    int   dreq;
    int   we_bad;
    logic wb;
    logic run_at_commit;
    chk({name, "_start"}, state, 1);
    op = o; Reg_load = rl; mem_load = ml; do_store = st;
    jump = jp; ALUbnc = bnc; br_taken = bt;
    sb.push_back('{rf: legal_op(o) & rl, sel: legal_op(o) & (jp | (bnc & bt))});
    dreq = 0; we_bad = 0; wb = 1'b0;
    for (cyc = 1; cyc <= 60; cyc++) begin
      if (dmem_req) begin
        dreq++;
        if (dmem_we !== st) we_bad++;
      end
      if (state == 3'd5) wb = 1'b1;
      if (retire === 1'b1) break;
      @(negedge clk);
    end
    run_at_commit = run;
    chk({name, "_latency"}, cyc, exp_lat);
    chk({name, "_dmem_req_cycles"}, dreq, exp_dreq);
    chk({name, "_dmem_we_bad"}, we_bad, 0);
    chk({name, "_wb_visited"}, wb, exp_wb);
    @(negedge clk);
    chk({name, "_retire_width"}, retire, 0);
    chk({name, "_next_state"}, state, run_at_commit ? 1 : 6);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waits;
    int cnt0;
    rst = 1'b1; run = 1'b0; op = '0;
    Reg_load = 0; mem_load = 0; do_store = 0; jump = 0; ALUbnc = 0; br_taken = 0;
    repeat (2) @(negedge clk);
    chk("reset_state", state, 0);
    chk("reset_outs", {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, rf_we, retire, mem_err}, 0);
    chk("pc_init", pc_init, 32'h0000_1000);

    // Reset in the middle of a stalled fetch.
    imem_lat = 1000;
    rst = 1'b0; run = 1'b1;
    @(negedge clk);
    chk("fetch_enter", state, 1);
    @(negedge clk);
    chk("fetch_hold_req", imem_req, 1);
    #2 rst = 1'b1;
    #1 chk("async_rst_state", state, 0);
    @(negedge clk);
    chk("rst_mid_fetch_outs", {state, imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, rf_we, retire, mem_err}, 0);
    imem_lat = 0;
    rst = 1'b0;
    @(negedge clk);
    chk("release_state", state, 1);
    chk("ir_we_cycle1", ir_we, 1);

    run_instr("addi",    7'b0010011, 1, 0, 0, 0, 0, 0, 4, 0, 1);
    run_instr("lw0",     7'b0000011, 1, 1, 0, 0, 0, 0, 5, 1, 1);
    dmem_lat = 3;
    run_instr("lw3",     7'b0000011, 1, 1, 0, 0, 0, 0, 8, 4, 1);
    chk("ready_wins_no_err", mem_err, 0);
    dmem_lat = 0;
    run_instr("sw0",     7'b0100011, 0, 0, 1, 0, 0, 0, 4, 1, 0);
    dmem_lat = 2;
    run_instr("sw2",     7'b0100011, 0, 0, 1, 0, 0, 0, 6, 3, 0);
    dmem_lat = 0;
    run_instr("beq_t",   7'b1100011, 0, 0, 0, 0, 1, 1, 4, 0, 1);
    run_instr("beq_nt",  7'b1100011, 0, 0, 0, 0, 1, 0, 4, 0, 1);
    run_instr("jal",     7'b1101111, 1, 0, 0, 1, 0, 0, 4, 0, 1);
    run_instr("add",     7'b0110011, 1, 0, 0, 0, 0, 1, 4, 0, 1);
`ifndef ILLEGAL_TRAP_EN
    run_instr("illegal", 7'b0000000, 1, 0, 0, 1, 1, 1, 4, 0, 1);
`endif

    // run dropped mid-instruction: finishes, then halts.
    run = 1'b0;
    run_instr("halt_addi", 7'b0010011, 1, 0, 0, 0, 0, 0, 4, 0, 1);
    @(negedge clk);
    chk("halt_stay", state, 6);
    chk("halt_no_pc_we", pc_we, 0);
    run = 1'b1;
    @(negedge clk);
    chk("halt_resume", state, 1);

    // Data memory never responds: timeout after 4 waiting cycles.
    dmem_lat = 1000;
    cnt0 = retire_cnt;
    op = 7'b0000011; Reg_load = 1; mem_load = 1; do_store = 0; jump = 0; ALUbnc = 0;
    waits = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (state == 3'd6) break;
      if (dmem_req && !dmem_ready) waits++;
    end
    chk("timeout_waits", waits, 4);
    chk("timeout_state", state, 6);
    chk("timeout_mem_err", mem_err, 1);
    chk("timeout_no_retire", retire_cnt, cnt0);
    @(negedge clk);
    chk("mem_err_sticky", mem_err, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mem_err_rst_clear", mem_err, 0);
    dmem_lat = 0;

`ifdef ILLEGAL_TRAP_EN
    rst = 1'b0; run = 1'b1;
    @(negedge clk);
    cnt0 = retire_cnt;
    op = 7'b0000000; Reg_load = 1; mem_load = 0; do_store = 0;
    waits = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (pc_we || rf_we) waits++;
    end
    chk("trap_state", state, 7);
    chk("trap_flag", trap, 1);
    chk("trap_no_retire", retire_cnt, cnt0);
    chk("trap_no_strobes", waits, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("trap_rst_state", state, 0);
`endif

    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
